// File: rtl/div_seq_ctrl_if.sv
// Request/response bundle between the execute stage and the divide sequencer.
// master = execute stage (issues requests, consumes results),
// slave  = div_seq_ctrl.
interface div_seq_ctrl_if #(
  parameter int XLEN = 64
);
  logic            req_valid;
  logic            req_ready;
  logic [3:0]      req_op;
  logic            req_word;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_result;
  logic [2:0]      resp_status;

  modport master (
    output req_valid, req_op, req_word, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_status
  );

  modport slave (
    input  req_valid, req_op, req_word, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result, resp_status
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Divide sequencer for DIV/DIVU/REM/REMU (64-bit and W forms).
// Special cases are classified at accept and answered in one cycle; all other
// cases run a radix-2 restoring divide, one quotient bit per cycle, followed
// by a sign fix-up cycle.
// Optional build macro: DIV_EARLY_OUT_EN -- when defined, zero-dividend and
// divisor-larger-than-dividend cases also take the one-cycle fast path.
module div_seq_ctrl #(
  parameter int XLEN = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  div_seq_ctrl_if.slave bus,
  output logic          busy
);

  localparam int CW = $clog2(XLEN);

  // md_op_t codes handled here
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_DIVU = 4'd5;
  localparam logic [3:0] OP_REM  = 4'd6;
  localparam logic [3:0] OP_REMU = 4'd7;

  // div_status_t codes
  localparam logic [2:0] ST_NONE          = 3'd0;
  localparam logic [2:0] ST_ZERO_DIVISOR  = 3'd1;
  localparam logic [2:0] ST_OVERFLOW      = 3'd2;
  localparam logic [2:0] ST_ZERO_DIVIDEND = 3'd3;
  localparam logic [2:0] ST_SHORT_DIV     = 3'd4;

  // FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // W-form results are sign-extended from bit 31
  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] x,
                                                input logic w);
    return w ? {{(XLEN-32){x[31]}}, x[31:0]} : x;
  endfunction

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] result_q;
  logic [2:0]      status_q;

  // Iteration datapath and per-operation flags
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] abs_b_q;
  logic            word_q;
  logic            op_rem_q;
  logic            neg_quo_q;
  logic            neg_rem_q;

  // Accept-time decode
  logic            accept;
  logic            op_ok;
  logic            op_signed;
  logic            op_rem;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN-1:0] min_val;
  logic            fast_hit;
  logic [2:0]      fast_status;
  logic [XLEN-1:0] fast_q;
  logic [XLEN-1:0] fast_r;
  logic [XLEN-1:0] fast_res;

  // Iteration / fix-up combinational terms
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] fixup_res;

  assign bus.req_ready  = (state == S_IDLE) && !flush;
  assign bus.resp_valid = (state == S_DONE);
  assign bus.resp_result = result_q;
  assign bus.resp_status = status_q;
  assign busy   = (state != S_IDLE);
  assign accept = bus.req_valid && bus.req_ready;

  // Operand preparation and fast-path classification of the incoming request
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    op_ok       = 1'b0;
    op_signed   = 1'b0;
    op_rem      = 1'b0;
    fast_hit    = 1'b1;
    fast_status = ST_NONE;
    fast_q      = '0;
    fast_r      = '0;

    case (bus.req_op)
      OP_DIV:  begin op_ok = 1'b1; op_signed = 1'b1;                 end
      OP_DIVU: begin op_ok = 1'b1;                                   end
      OP_REM:  begin op_ok = 1'b1; op_signed = 1'b1; op_rem = 1'b1;  end
      OP_REMU: begin op_ok = 1'b1; op_rem = 1'b1;                    end
      default: ;
    endcase

    if (bus.req_word) begin
      a_ext = op_signed ? sext_word(bus.req_a, 1'b1)
                        : {{(XLEN-32){1'b0}}, bus.req_a[31:0]};
      b_ext = op_signed ? sext_word(bus.req_b, 1'b1)
                        : {{(XLEN-32){1'b0}}, bus.req_b[31:0]};
      min_val = {{(XLEN-31){1'b1}}, 31'b0};
    end else begin
      a_ext   = bus.req_a;
      b_ext   = bus.req_b;
      min_val = {1'b1, {(XLEN-1){1'b0}}};
    end

    a_neg = op_signed && a_ext[XLEN-1];
    b_neg = op_signed && b_ext[XLEN-1];
    abs_a = a_neg ? -a_ext : a_ext;
    abs_b = b_neg ? -b_ext : b_ext;

    if (!op_ok) begin
      fast_status = ST_NONE;
    end else if (b_ext == '0) begin
      fast_status = ST_ZERO_DIVISOR;
      fast_q      = '1;
      fast_r      = a_ext;
    end else if (op_signed && (a_ext == min_val) && (b_ext == '1)) begin
      fast_status = ST_OVERFLOW;
      fast_q      = a_ext;
`ifdef DIV_EARLY_OUT_EN
    end else if (abs_a == '0) begin
      fast_status = ST_ZERO_DIVIDEND;
    end else if (abs_b > abs_a) begin
      fast_status = ST_SHORT_DIV;
      fast_r      = a_ext;
`endif
    end else begin
      fast_hit = 1'b0;
    end

    fast_res = sext_word(op_rem ? fast_r : fast_q, bus.req_word);
  end

  // One restoring step and the final sign fix-up
  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    diff      = rem_shift - {1'b0, abs_b_q};
    quo_fix   = neg_quo_q ? -quo_q : quo_q;
    rem_fix   = neg_rem_q ? -rem_q : rem_q;
    fixup_res = sext_word(op_rem_q ? rem_fix : quo_fix, word_q);
  end

  // Control: FSM, iteration counter and the registered response
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // here samples the pre-edge values, independent of statement order.
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      result_q <= '0;
      status_q <= ST_NONE;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (fast_hit) begin
              result_q <= fast_res;
              status_q <= fast_status;
              state    <= S_DONE;
            end else begin
              cnt      <= bus.req_word ? CW'(31) : CW'(XLEN-1);
              status_q <= ST_NONE;
              state    <= S_CALC;
            end
          end
        end
        S_CALC: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= S_FIXUP;
        end
        S_FIXUP: begin
          result_q <= fixup_res;
          state    <= S_DONE;
        end
        S_DONE: begin
          if (bus.resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Divide datapath: operand capture at accept, one shift/subtract per CALC cycle
  always_ff @(posedge clk) begin
    // NOTE: these registers carry no reset; they are always loaded at accept
    // before being read, and the FSM alone decides when their contents matter.
    if (state == S_IDLE && accept) begin
      rem_q     <= '0;
      // W forms shift the 32-bit dividend to the top so its MSB enters first
      quo_q     <= bus.req_word ? (abs_a << 32) : abs_a;
      abs_b_q   <= abs_b;
      word_q    <= bus.req_word;
      op_rem_q  <= op_rem;
      neg_quo_q <= op_signed && (a_neg ^ b_neg);
      neg_rem_q <= a_neg;
    end else if (state == S_CALC) begin
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= rem_shift[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule
